filter_bank_rr: RTL
===================

FILTER_BANK_RR -- requirements
Module: filter_bank_rr

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of r2/dx/dy/dz words.
REQ-002 Parameter NUM_FILTER, 4, number of filter channels feeding the bank (2..8).
REQ-003 Parameter FILTER_BUFFER_DEPTH, 8, entries per channel buffer (power of 2).
REQ-004 Parameter FILTER_BUFFER_ADDR_WIDTH, 3, log2(FILTER_BUFFER_DEPTH).
REQ-005 Parameter AF_MARGIN, 2, free-entry count at or below which back_pressure asserts.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 in_valid  in  NUM_FILTER  per-channel write strobe from filter logic.
REQ-009 in_data  in  NUM_FILTER*4*DATA_WIDTH  per-channel {r2,dx,dy,dz}, channel 0 in LSBs.
REQ-010 back_pressure  out  NUM_FILTER  per-channel almost-full.
REQ-011 out_ready  in  1  force pipeline accepts output this cycle.
REQ-012 out_valid  out  1  r2/dx/dy/dz hold a valid pair.
REQ-013 r2, dx, dy, dz  out  DATA_WIDTH each  selected pair data.
REQ-014 out_sel  out  log2(NUM_FILTER) (min 1)  channel index of current output.
REQ-015 all_empty  out  1  all buffers empty and out_valid low.
REQ-016 overflow  out  NUM_FILTER  sticky per-channel write-while-full flag.

Function
REQ-017 Each channel SHALL own one FIFO of FILTER_BUFFER_DEPTH entries of 4*DATA_WIDTH bits, pointer wrap modulo depth.
REQ-018 Write in cycle N SHALL be poppable in cycle N+1; earliest out_valid is cycle N+2.
REQ-019 Load condition: out_valid==0 or out_ready==1; only then SHALL the arbiter grant.
REQ-020 Arbiter SHALL grant the first non-empty channel searching from last_grant+1 upward, wrapping; last_grant reset value NUM_FILTER-1 (first search starts at channel 0).
REQ-021 last_grant SHALL update only on a grant; no grant leaves it unchanged.
REQ-022 On grant, granted FIFO SHALL pop and output registers SHALL load its head next edge with out_valid=1, out_sel=channel.
REQ-023 Load condition true with no non-empty channel: out_valid SHALL go 0; data registers hold.
REQ-024 out_valid=1 and out_ready=0: r2/dx/dy/dz/out_sel SHALL remain stable.
REQ-025 Sustained out_ready=1 with data available SHALL give one output per cycle.
REQ-026 Push and pop same channel same cycle: both SHALL succeed, count unchanged, including when full.
REQ-027 in_valid on full channel without same-cycle pop: write SHALL be dropped, overflow[ch] set until reset.
REQ-028 back_pressure[ch] SHALL be registered, high when free entries <= AF_MARGIN after the current edge's updates.
REQ-029 all_empty SHALL be combinational: all counts zero and out_valid==0.
REQ-030 in_valid on empty channel SHALL never be granted the same cycle (no bypass).

Reset
REQ-031 rst low SHALL asynchronously clear: FIFO pointers/counts, out_valid, r2/dx/dy/dz, out_sel, overflow, back_pressure to 0; last_grant to NUM_FILTER-1.
REQ-032 Reset mid-operation SHALL discard all buffered and in-flight pairs; no output after release until new writes.
REQ-033 Reset release synchronous-safe: first write accepted on first rising edge with rst high.

Structure
REQ-034 Shared package filter_bank_pkg SHALL hold the pair word layout (field offsets r2/dx/dy/dz), CUTOFF_2 constant 32'h43100000, and channel-index width function.
REQ-035 One sub-module filter_buffer (sync FIFO with count, full, empty, almost-full) SHALL be instantiated NUM_FILTER times; arbiter and output stage stay in the top.

Verification
REQ-036 Single write ch2 {r2=0x3F800000,dx=1,dy=2,dz=3} at cycle 0, out_ready=1 -> out_valid=1 cycle 2, out_sel=2, data matches, all_empty=1 cycle 3.
REQ-037 All 4 channels hold 3 entries, out_ready=1 -> out_sel sequence 0,1,2,3,0,1,2,3,0,1,2,3, 12 consecutive valid cycles.
REQ-038 out_ready=0 for 5 cycles with out_valid=1 -> outputs stable, no pops; back_pressure[ch0] high once ch0 count reaches 6.
REQ-039 9 writes to ch1 without pops -> 9th dropped, overflow[1]=1, 8 entries drain in order.
REQ-040 Full ch3 with simultaneous push+pop -> count stays 8, overflow[3]=0, FIFO order preserved.
REQ-041 rst low while 5 entries buffered and out_valid=1 -> all outputs 0 immediately, no output after release.

Source files
------------

// File: rtl/filter_bank_pkg.sv
// Shared definitions for the filter bank: pair word layout, cutoff constant
// and the channel-index width helper.
package filter_bank_pkg;

  // Field position inside a pair word, in DATA_WIDTH units ({r2,dx,dy,dz}, dz in LSBs)
  localparam int FLD_DZ      = 0;
  localparam int FLD_DY      = 1;
  localparam int FLD_DX      = 2;
  localparam int FLD_R2      = 3;
  localparam int PAIR_FIELDS = 4;

  localparam logic [31:0] CUTOFF_2 = 32'h43100000;

  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/filter_buffer.sv
// Per-channel sync FIFO with occupancy count, registered almost-full and a
// sticky overflow flag for writes dropped while full.
module filter_buffer #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int AF_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count_nxt;
  logic             full, do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count       <= count_nxt;
      almost_full <= (((AW+1)'(DEPTH) - count_nxt) <= (AW+1)'(AF_MARGIN));
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/filter_bank_rr.sv
// Bank of per-channel pair buffers drained by a round-robin arbiter into a
// single registered output stage with valid/ready style hold.
module filter_bank_rr
  import filter_bank_pkg::*;
#(
  parameter int DATA_WIDTH               = 32,
  parameter int NUM_FILTER               = 4,
  parameter int FILTER_BUFFER_DEPTH      = 8,
  parameter int FILTER_BUFFER_ADDR_WIDTH = 3,
  parameter int AF_MARGIN                = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_FILTER-1:0]                      in_valid,
  input  logic [NUM_FILTER*PAIR_FIELDS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_FILTER-1:0]                      back_pressure,
  input  logic                                       out_ready,
  output logic                                       out_valid,
  output logic [DATA_WIDTH-1:0]                      r2,
  output logic [DATA_WIDTH-1:0]                      dx,
  output logic [DATA_WIDTH-1:0]                      dy,
  output logic [DATA_WIDTH-1:0]                      dz,
  output logic [chan_w(NUM_FILTER)-1:0]              out_sel,
  output logic                                       all_empty,
  output logic [NUM_FILTER-1:0]                      overflow
);

  localparam int PW = PAIR_FIELDS * DATA_WIDTH;
  localparam int SW = chan_w(NUM_FILTER);
  localparam int AW = FILTER_BUFFER_ADDR_WIDTH;

  logic [NUM_FILTER-1:0][PW-1:0] head;
  logic [NUM_FILTER-1:0][AW:0]   count;
  logic [NUM_FILTER-1:0]         empty, idle, pop;
  logic [SW-1:0]                 last_grant, gnt_idx;
  logic                          load, gnt_any;

  for (genvar g = 0; g < NUM_FILTER; g++) begin : g_ch
    assign pop[g]  = gnt_any && (gnt_idx == SW'(g));
    assign idle[g] = (count[g] == '0);

    filter_buffer #(
      .WIDTH     (PW),
      .DEPTH     (FILTER_BUFFER_DEPTH),
      .AW        (AW),
      .AF_MARGIN (AF_MARGIN)
    ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push        (in_valid[g]),
      .pop         (pop[g]),
      .wdata       (in_data[g*PW +: PW]),
      .head        (head[g]),
      .count       (count[g]),
      .empty       (empty[g]),
      .almost_full (back_pressure[g]),
      .overflow    (overflow[g])
    );
  end

  assign load      = !out_valid || out_ready;
  assign all_empty = (&idle) && !out_valid;

  // Search starts one past the last winner and wraps; empty reflects only
  // registered state, so same-cycle writes are never bypassed.
  always_comb begin
    int            c;
    logic [SW-1:0] cs;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    cs      = '0;
    for (int i = 1; i <= NUM_FILTER; i++) begin
      c  = (int'(last_grant) + i) % NUM_FILTER;
      cs = SW'(c);
      if (!gnt_any && !empty[cs]) begin
        gnt_any = 1'b1;
        gnt_idx = cs;
      end
    end
    if (!load) gnt_any = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_sel    <= '0;
      r2         <= '0;
      dx         <= '0;
      dy         <= '0;
      dz         <= '0;
      last_grant <= SW'(NUM_FILTER - 1);
    end else if (gnt_any) begin
      out_valid  <= 1'b1;
      out_sel    <= gnt_idx;
      last_grant <= gnt_idx;
      r2         <= head[gnt_idx][FLD_R2*DATA_WIDTH +: DATA_WIDTH];
      dx         <= head[gnt_idx][FLD_DX*DATA_WIDTH +: DATA_WIDTH];
      dy         <= head[gnt_idx][FLD_DY*DATA_WIDTH +: DATA_WIDTH];
      dz         <= head[gnt_idx][FLD_DZ*DATA_WIDTH +: DATA_WIDTH];
    end else if (load) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
